// File: rtl/rgb_fade_scheduler.sv
// RGB PWM duty sequencer: free-running PWM counter, six-keyframe hue wheel of fades and holds,
// and one-shot colour overrides; duties only change on the PWM period-end edge.
module rgb_fade_scheduler #(
    parameter int PWM_BITS     = 10,
    parameter int STEP         = 8,
    parameter int HOLD_PERIODS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                ovr_valid,
    output logic                ovr_ready,
    input  logic [PWM_BITS-1:0] ovr_red,
    input  logic [PWM_BITS-1:0] ovr_green,
    input  logic [PWM_BITS-1:0] ovr_blue,
    output logic [PWM_BITS-1:0] pwm_counter,
    output logic [PWM_BITS-1:0] pwm_red,
    output logic [PWM_BITS-1:0] pwm_green,
    output logic [PWM_BITS-1:0] pwm_blue,
    output logic [2:0]          segment,
    output logic                fading
);

    localparam int                HW        = $clog2(HOLD_PERIODS + 1);
    localparam logic [PWM_BITS-1:0] MAX     = '1;
    localparam logic [PWM_BITS:0] STEP_W    = (PWM_BITS + 1)'(STEP);
    localparam logic [HW-1:0]     HOLD_INIT = HW'(HOLD_PERIODS);

    // state      | meaning
    // S_HOLD     | resting on the current keyframe, counting hold periods
    // S_FADE     | stepping duties toward the current keyframe once per period
    // S_OVR_WAIT | override latched, waiting for the next period end to load it
    // S_OVR_HOLD | showing override colour, counting hold periods
    typedef enum logic [1:0] {S_HOLD, S_FADE, S_OVR_WAIT, S_OVR_HOLD} state_t;

    state_t              state, state_nx;
    logic [HW-1:0]       hold_cnt, hold_nx;
    logic [2:0]          seg_nx;
    logic [PWM_BITS-1:0] red_nx, green_nx, blue_nx;
    logic [PWM_BITS-1:0] lat_red, lat_green, lat_blue;
    logic [PWM_BITS-1:0] lat_red_nx, lat_green_nx, lat_blue_nx;
    logic [PWM_BITS-1:0] tgt_red, tgt_green, tgt_blue;
    logic [PWM_BITS-1:0] step_red, step_green, step_blue;
    logic                pe;
    logic                xfer;

    // One extra bit of headroom so the distance test and the step never wrap.
    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS:0]   c;
        logic [PWM_BITS:0]   t;
        logic [PWM_BITS-1:0] res;
        c   = {1'b0, cur};
        t   = {1'b0, tgt};
        res = cur;
        if (t > c) begin
            if ((t - c) <= STEP_W) res = tgt;
            else                   res = PWM_BITS'(c + STEP_W);
        end else if (c > t) begin
            if ((c - t) <= STEP_W) res = tgt;
            else                   res = PWM_BITS'(c - STEP_W);
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_counter <= '0;
        else     pwm_counter <= pwm_counter + 1'b1;
    end

    assign pe        = (pwm_counter == MAX);
    assign ovr_ready = (state != S_OVR_WAIT);
    assign fading    = (state == S_FADE);
    assign xfer      = ovr_valid && ovr_ready;

    always_comb begin
        tgt_red   = '0;
        tgt_green = '0;
        tgt_blue  = '0;
        case (segment)
            3'd0: tgt_red = MAX;
            3'd1: begin tgt_red = MAX; tgt_green = MAX; end
            3'd2: tgt_green = MAX;
            3'd3: begin tgt_green = MAX; tgt_blue = MAX; end
            3'd4: tgt_blue = MAX;
            3'd5: begin tgt_red = MAX; tgt_blue = MAX; end
            default: ;
        endcase
    end

    assign step_red   = step_toward(pwm_red, tgt_red);
    assign step_green = step_toward(pwm_green, tgt_green);
    assign step_blue  = step_toward(pwm_blue, tgt_blue);

    // A transfer wins over any period-end action on the same edge, which defers its load a period.
    always_comb begin
        state_nx     = state;
        hold_nx      = hold_cnt;
        seg_nx       = segment;
        red_nx       = pwm_red;
        green_nx     = pwm_green;
        blue_nx      = pwm_blue;
        lat_red_nx   = lat_red;
        lat_green_nx = lat_green;
        lat_blue_nx  = lat_blue;
        if (xfer) begin
            lat_red_nx   = ovr_red;
            lat_green_nx = ovr_green;
            lat_blue_nx  = ovr_blue;
            state_nx     = S_OVR_WAIT;
        end else if (pe && en) begin
            case (state)
                S_HOLD, S_OVR_HOLD: begin
                    if (hold_cnt == HW'(1)) begin
                        state_nx = S_FADE;
                        if (state == S_HOLD)
                            seg_nx = (segment == 3'd5) ? 3'd0 : segment + 3'd1;
                    end else begin
                        hold_nx = hold_cnt - HW'(1);
                    end
                end
                S_FADE: begin
                    red_nx   = step_red;
                    green_nx = step_green;
                    blue_nx  = step_blue;
                    if (step_red == tgt_red && step_green == tgt_green && step_blue == tgt_blue) begin
                        state_nx = S_HOLD;
                        hold_nx  = HOLD_INIT;
                    end
                end
                S_OVR_WAIT: begin
                    red_nx   = lat_red;
                    green_nx = lat_green;
                    blue_nx  = lat_blue;
                    hold_nx  = HOLD_INIT;
                    state_nx = S_OVR_HOLD;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_HOLD;
            hold_cnt  <= HOLD_INIT;
            segment   <= 3'd0;
            pwm_red   <= MAX;
            pwm_green <= '0;
            pwm_blue  <= '0;
            lat_red   <= '0;
            lat_green <= '0;
            lat_blue  <= '0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            segment   <= seg_nx;
            pwm_red   <= red_nx;
            pwm_green <= green_nx;
            pwm_blue  <= blue_nx;
            lat_red   <= lat_red_nx;
            lat_green <= lat_green_nx;
            lat_blue  <= lat_blue_nx;
        end
    end

endmodule

// File: doc/rgb_fade_scheduler.md
Name: rgb_fade_scheduler

Overview:
- Drives the RGB PWM comparator stage. Owns the free-running PWM counter and sequences the three duty registers through a fixed six-keyframe hue wheel: linear fades separated by holds.
- Also accepts one-shot colour overrides from a requester over a valid/ready handshake.
- Duty registers change only at PWM period boundaries, so no output pulse is ever truncated or doubled.
- Sits between the top level and the comparator stage; the comparators read pwm_counter and the three duty outputs.

Parameters:
- PWM_BITS, 10, width of the counter and duty values; period = 2^PWM_BITS clocks, MAX = 2^PWM_BITS-1.
- STEP, 8, duty change per period during a fade (1..MAX).
- HOLD_PERIODS, 64, number of PWM periods spent in each hold (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  1 = FSM advances at period ends; 0 = sequence frozen (counter keeps running).
- ovr_valid  input  1  override request.
- ovr_ready  output  1  override can be accepted this cycle.
- ovr_red  input  PWM_BITS  override red duty.
- ovr_green  input  PWM_BITS  override green duty.
- ovr_blue  input  PWM_BITS  override blue duty.
- pwm_counter  output  PWM_BITS  free-running PWM counter.
- pwm_red  output  PWM_BITS  red duty.
- pwm_green  output  PWM_BITS  green duty.
- pwm_blue  output  PWM_BITS  blue duty.
- segment  output  3  current keyframe index, 0..5.
- fading  output  1  high while in FADE.

Behaviour:
- Reset (async, immediate, including mid-fade or mid-override):
  - pwm_counter=0; duties = K0 = (MAX,0,0); segment=0; state HOLD; hold_cnt=HOLD_PERIODS; ovr_ready=1; fading=0.
- Counter: increments every clk regardless of en; wraps MAX->0.
  - Period end (PE) = clock edge on which pwm_counter==MAX. All duty, segment and state updates happen only on PE edges, so new duties take effect when the counter reads 0.
- Keyframes (R,G,B), with M=MAX:
  - K0=(M,0,0), K1=(M,M,0), K2=(0,M,0), K3=(0,M,M), K4=(0,0,M), K5=(M,0,M).
- States: HOLD, FADE, OVR_WAIT, OVR_HOLD. All PE actions below require en=1; with en=0 the state and all counters are frozen.
- HOLD: at each PE, hold_cnt decrements.
  - At a PE with hold_cnt==1: segment <= (segment+1) mod 6 (5 wraps to 0); state FADE.
- FADE: at each PE, each channel moves toward Ksegment by STEP.
  - Saturating: if |target-duty| <= STEP, duty = target. Channels are independent; no overshoot and no width overflow (compute at PWM_BITS+1).
  - At the PE on which all three channels equal the target: state HOLD, hold_cnt=HOLD_PERIODS.
- Override handshake:
  - ovr_ready = 1 in HOLD, FADE and OVR_HOLD; 0 in OVR_WAIT.
  - Transfer on any edge with ovr_valid & ovr_ready. Accept happens irrespective of en.
  - On transfer: latch the three values; state OVR_WAIT.
  - A transfer during OVR_HOLD replaces the previous override and returns to OVR_WAIT.
- OVR_WAIT: at the first PE strictly after the transfer edge, duties <= latched values; hold_cnt=HOLD_PERIODS; state OVR_HOLD.
  - A transfer occurring on a PE edge loads at the following PE, not that one.
- OVR_HOLD: counts like HOLD.
  - On expiry: state FADE toward the current segment's keyframe; segment is not incremented. Multi-channel fade is allowed.
- An override preempts FADE or HOLD mid-way; the duties reached so far are discarded.
- fading = (state==FADE). segment changes only in HOLD->FADE.

Test Plan (bench uses PWM_BITS=10, STEP=256, HOLD_PERIODS=2):
- Reset, en=1:
  - Counter is 0 after reset and reads 1023 then 0 on consecutive clocks.
  - Duties (1023,0,0), segment 0 for 2 periods.
  - At the 2nd PE: segment=1, fading=1.
- Fade up, continuing the reset run:
  - Green reads 256, 512, 768, 1023 after successive PEs; fading drops on the 1023 PE.
  - Duties never change when the counter is not 0.
- Full wheel: run 6 segments; segment goes 5->0, duties return to (1023,0,0); ramp down 1023->767->511->255->0 observed on red in segment 2.
- Override mid-fade: send (100,200,300) at counter=500 during FADE.
  - ovr_ready is 0 until the next PE; duties become (100,200,300) exactly at that PE.
  - Held 2 periods, then a 3-channel fade to the current keyframe.
- Override on a PE edge: load is deferred a full period.
  - Second override during OVR_HOLD replaces the first at the next PE.
- en=0 mid-fade freezes duties and segment for 5 periods while the counter runs; override still accepted but not loaded until en=1.
  - Async rst mid-fade restores reset values immediately, without a clock edge.
